// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: latches decode's payload behind a
// valid/allowin handshake, drives the external ALU and forwards results to memory.
module exe_stage #(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_alu_op,
  input  logic        ds_src1_is_sa,
  input  logic        ds_src1_is_pc,
  input  logic        ds_src2_is_simm,
  input  logic        ds_src2_is_zimm,
  input  logic        ds_src2_is_8,
  input  logic [15:0] ds_imm,
  input  logic [31:0] ds_rs_value,
  input  logic [31:0] ds_rt_value,
  input  logic [4:0]  ds_dest,
  input  logic        ds_gr_we,
  input  logic        ds_mem_we,
  input  logic        ds_load,
  input  logic        ds_ov_check,
  output logic [31:0] alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  input  logic        overflow,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [31:0] es_store_data,
  output logic [4:0]  es_dest,
  output logic        es_gr_we_o,
  output logic        es_mem_we_o,
  output logic        es_load_o,
  output logic        es_ov_exc,
  output logic        es_fwd_valid,
  output logic [4:0]  es_fwd_dest,
  output logic        es_fwd_is_load
);

  logic        es_valid;
  logic        es_ready_go;
  logic [11:0] es_alu_op;
  logic        es_src1_is_sa;
  logic        es_src1_is_pc;
  logic        es_src2_is_simm;
  logic        es_src2_is_zimm;
  logic        es_src2_is_8;
  logic [15:0] es_imm;
  logic [31:0] es_rs_value;
  logic [31:0] es_rt_value;
  logic        es_gr_we;
  logic        es_mem_we;
  logic        es_load;
  logic        es_ov_check;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  // Payload only loads on an accepted instruction so a stalled one stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid        <= 1'b0;
      es_pc           <= PC_RESET;
      es_alu_op       <= '0;
      es_src1_is_sa   <= 1'b0;
      es_src1_is_pc   <= 1'b0;
      es_src2_is_simm <= 1'b0;
      es_src2_is_zimm <= 1'b0;
      es_src2_is_8    <= 1'b0;
      es_imm          <= '0;
      es_rs_value     <= '0;
      es_rt_value     <= '0;
      es_dest         <= '0;
      es_gr_we        <= 1'b0;
      es_mem_we       <= 1'b0;
      es_load         <= 1'b0;
      es_ov_check     <= 1'b0;
    end else begin
      if (es_allowin) begin
        es_valid <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin) begin
        es_pc           <= ds_pc;
        es_alu_op       <= ds_alu_op;
        es_src1_is_sa   <= ds_src1_is_sa;
        es_src1_is_pc   <= ds_src1_is_pc;
        es_src2_is_simm <= ds_src2_is_simm;
        es_src2_is_zimm <= ds_src2_is_zimm;
        es_src2_is_8    <= ds_src2_is_8;
        es_imm          <= ds_imm;
        es_rs_value     <= ds_rs_value;
        es_rt_value     <= ds_rt_value;
        es_dest         <= ds_dest;
        es_gr_we        <= ds_gr_we;
        es_mem_we       <= ds_mem_we;
        es_load         <= ds_load;
        es_ov_check     <= ds_ov_check;
      end
    end
  end

  always_comb begin
    alu_src1 = es_rs_value;
    if (es_src1_is_sa) begin
      alu_src1 = {27'b0, es_imm[10:6]};
    end else if (es_src1_is_pc) begin
      alu_src1 = es_pc;
    end
  end

  always_comb begin
    alu_src2 = es_rt_value;
    if (es_src2_is_simm) begin
      alu_src2 = {{16{es_imm[15]}}, es_imm};
    end else if (es_src2_is_zimm) begin
      alu_src2 = {16'b0, es_imm};
    end else if (es_src2_is_8) begin
      alu_src2 = 32'd8;
    end
  end

  assign alu_op        = {20'b0, es_alu_op};
  assign es_result     = alu_result;
  assign es_store_data = es_rt_value;

  // A trapping overflow suppresses architectural writes; the result still flows.
  assign es_ov_exc   = es_valid && es_ov_check && overflow;
  assign es_gr_we_o  = es_valid && es_gr_we && !es_ov_exc;
  assign es_mem_we_o = es_valid && es_mem_we && !es_ov_exc;
  assign es_load_o   = es_valid && es_load;

  assign es_fwd_valid   = es_valid && es_gr_we_o && (es_dest != 5'd0);
  assign es_fwd_is_load = es_fwd_valid && es_load;
  assign es_fwd_dest    = es_dest;

endmodule
